hub75_scanout: RTL and testbench

- Downstream consumer of the pixel RAM. Reads one 32-bit pixel pair per address: rdata1 is the top-half pixel, rdata2 the bottom-half pixel, both RGB565.
- Drives a HUB75 panel with binary-coded modulation (BCM): per scan row, one bit-plane at a time, it shifts COLS columns, latches, then lights the row for a plane-weighted time.
- Also owns the RAM read port: raddr plus the rclk read-enable strobe.

---
 rtl/hub75_pkg.sv | 38 +++
 rtl/hub75_bcm_timer.sv | 61 ++++++
 rtl/hub75_scanout.sv | 176 +++++++++++++++++
 tb/tb_hub75_scanout.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 scan-out: FSM state encoding, RGB565 field
// positions and the bit-plane extraction helper.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_RD,
    SHIFT_DT,
    SHIFT_END,
    LATCH,
    SHOW
  } state_e;

  localparam int RAM_AW  = 12;
  localparam int PLANE_W = 3;

  // LSB of each channel's top five bits within an RGB565 word.
  localparam int R_LSB = 11;
  localparam int G_LSB = 6;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  function automatic rgb_t plane_bits(input logic [15:0] px, input logic [PLANE_W-1:0] plane);
    logic [15:0] shifted;
    rgb_t        bits;
    shifted = px >> plane;
    bits.r  = shifted[R_LSB];
    bits.g  = shifted[G_LSB];
    bits.b  = shifted[B_LSB];
    return bits;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// BCM on-time counter: loads the plane weight, counts down through SHOW and gates OE.
// Optional HUB75_SCANOUT_BRIGHTNESS_EN scales the lit part of each plane by brightness/256.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int BASE_TICKS = 8,
  parameter int PLANES     = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               run,
  input  logic [PLANE_W-1:0] plane,
`ifdef HUB75_SCANOUT_BRIGHTNESS_EN
  input  logic [7:0]         brightness,
`endif
  output logic               done,
  output logic               oe_on
);

  localparam int TICK_W = $clog2(BASE_TICKS << (PLANES - 1)) + 1;
  localparam logic [TICK_W-1:0] ONE = TICK_W'(1);

  logic [TICK_W-1:0] count_q, count_d;
  logic [TICK_W-1:0] weight;

  assign weight = TICK_W'(BASE_TICKS) << plane;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = weight - ONE;
    end else if (run && count_q != '0) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

`ifdef HUB75_SCANOUT_BRIGHTNESS_EN
  localparam int PROD_W = TICK_W + 8;
  logic [TICK_W-1:0] elapsed;
  logic [PROD_W-1:0] lit_ticks;

  // The SHOW length is unchanged; only its leading part is lit.
  assign elapsed   = weight - ONE - count_q;
  assign lit_ticks = (PROD_W'(weight) * PROD_W'(brightness)) >> 8;
  assign oe_on     = PROD_W'(elapsed) < lit_ticks;
`else
  assign oe_on = 1'b1;
`endif

endmodule

// File: rtl/hub75_scanout.sv
// HUB75 BCM scan-out: reads pixel pairs from the pixel RAM, shifts one bit-plane per row,
// latches and lights it for a plane-weighted time. Option: HUB75_SCANOUT_BRIGHTNESS_EN.
module hub75_scanout
  import hub75_pkg::*;
#(
  parameter int COLS       = 64,
  parameter int ROW_BITS   = 5,
  parameter int PLANES     = 5,
  parameter int BASE_TICKS = 8
) (
  input  logic                sysclk,
  input  logic                rst_n,
`ifdef HUB75_SCANOUT_BRIGHTNESS_EN
  input  logic [7:0]          brightness,
`endif
  input  logic                enable,
  output logic [RAM_AW-1:0]   raddr,
  output logic                rclk,
  input  logic [15:0]         rdata1,
  input  logic [15:0]         rdata2,
  output logic                hub_r1,
  output logic                hub_g1,
  output logic                hub_b1,
  output logic                hub_r2,
  output logic                hub_g2,
  output logic                hub_b2,
  output logic                hub_clk,
  output logic                hub_lat,
  output logic                hub_oe_n,
  output logic [ROW_BITS-1:0] hub_addr,
  output logic                frame_done
);

  localparam int COL_W = $clog2(COLS);
  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(PLANES - 1);

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [PLANE_W-1:0]  plane_q, plane_d;
  rgb_t                top_q, top_d, bot_q, bot_d;
  logic [ROW_BITS-1:0] hub_addr_q, hub_addr_d;
  logic [RAM_AW-1:0]   raddr_q, raddr_d;
  logic                rclk_q, rclk_d;
  logic                hub_clk_q, hub_clk_d;
  logic                hub_lat_q, hub_lat_d;
  logic                hub_oe_n_q, hub_oe_n_d;
  logic                frame_done_q, frame_done_d;
  logic                timer_done, timer_oe_on;

  hub75_bcm_timer #(
    .BASE_TICKS(BASE_TICKS),
    .PLANES    (PLANES)
  ) u_timer (
    .clk       (sysclk),
    .rst_n     (rst_n),
    .load      (state_q == LATCH),
    .run       (state_q == SHOW),
    .plane     (plane_q),
`ifdef HUB75_SCANOUT_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .done      (timer_done),
    .oe_on     (timer_oe_on)
  );

  always_comb begin
    // NOTE: every signal gets its default first, so no path through the case infers a latch.
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    plane_d      = plane_q;
    top_d        = top_q;
    bot_d        = bot_q;
    hub_addr_d   = hub_addr_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SHIFT_RD;
          col_d   = '0;
        end
      end
      SHIFT_RD: state_d = SHIFT_DT;
      SHIFT_DT: begin
        top_d = plane_bits(rdata1, plane_q);
        bot_d = plane_bits(rdata2, plane_q);
        if (col_q != LAST_COL) begin
          col_d   = col_q + COL_W'(1);
          state_d = SHIFT_RD;
        end else begin
          state_d = SHIFT_END;
        end
      end
      SHIFT_END: state_d = LATCH;
      LATCH: begin
        hub_addr_d = row_q;
        state_d    = SHOW;
      end
      SHOW: begin
        if (timer_done) begin
          if (plane_q != LAST_PLANE) begin
            plane_d = plane_q + PLANE_W'(1);
          end else begin
            plane_d      = '0;
            row_d        = row_q + ROW_BITS'(1);
            frame_done_d = (row_q == '1);
          end
          col_d   = '0;
          state_d = enable ? SHIFT_RD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The read strobe lines up with SHIFT_RD so rdata is valid during SHIFT_DT.
    rclk_d  = (state_d == SHIFT_RD);
    raddr_d = rclk_d ? RAM_AW'({row_d, col_d}) : raddr_q;

    // Panel strobes trail the state by one cycle: each hub_clk rise then follows a full
    // cycle of stable colour data, and hub_lat rises only after the last clock pulse.
    hub_clk_d  = (state_q == SHIFT_RD && col_q != '0) || (state_q == SHIFT_END);
    hub_lat_d  = (state_q == LATCH);
    hub_oe_n_d = !(state_q == SHOW && timer_oe_on);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      top_q        <= '0;
      bot_q        <= '0;
      hub_addr_q   <= '0;
      raddr_q      <= '0;
      rclk_q       <= 1'b0;
      hub_clk_q    <= 1'b0;
      hub_lat_q    <= 1'b0;
      hub_oe_n_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      top_q        <= top_d;
      bot_q        <= bot_d;
      hub_addr_q   <= hub_addr_d;
      raddr_q      <= raddr_d;
      rclk_q       <= rclk_d;
      hub_clk_q    <= hub_clk_d;
      hub_lat_q    <= hub_lat_d;
      hub_oe_n_q   <= hub_oe_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign raddr      = raddr_q;
  assign rclk       = rclk_q;
  assign hub_r1     = top_q.r;
  assign hub_g1     = top_q.g;
  assign hub_b1     = top_q.b;
  assign hub_r2     = bot_q.r;
  assign hub_g2     = bot_q.g;
  assign hub_b2     = bot_q.b;
  assign hub_clk    = hub_clk_q;
  assign hub_lat    = hub_lat_q;
  assign hub_oe_n   = hub_oe_n_q;
  assign hub_addr   = hub_addr_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scanout.sv
// Self-checking bench for hub75_scanout: a RAM model feeds random pixels, and a
// pixel/plane-level reference checks every shift, latch, OE window and frame pulse.
`timescale 1ns/1ps
module tb_hub75_scanout;

  localparam int COLS     = 4;
  localparam int ROW_BITS = 1;
  localparam int PLANES   = 2;
`ifdef HUB75_SCANOUT_BRIGHTNESS_EN
  localparam int BASE     = 8;
`else
  localparam int BASE     = 2;
`endif
  localparam int ROWS   = 1 << ROW_BITS;
  localparam int NPIX   = COLS * ROWS;
  localparam int NPIX_W = $clog2(NPIX);

  logic                sysclk = 1'b0;
  logic                rst_n  = 1'b0;
  logic                enable = 1'b0;
  logic [11:0]         raddr;
  logic                rclk;
  logic [15:0]         rdata1 = '0;
  logic [15:0]         rdata2 = '0;
  logic                hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
  logic                hub_clk, hub_lat, hub_oe_n, frame_done;
  logic [ROW_BITS-1:0] hub_addr;
`ifdef HUB75_SCANOUT_BRIGHTNESS_EN
  logic [7:0]          brightness = 8'd255;
`endif

  logic [15:0] mem1 [NPIX];
  logic [15:0] mem2 [NPIX];

  always #5 sysclk = ~sysclk;

  hub75_scanout #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .PLANES(PLANES), .BASE_TICKS(BASE)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n),
`ifdef HUB75_SCANOUT_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .enable(enable), .raddr(raddr), .rclk(rclk), .rdata1(rdata1), .rdata2(rdata2),
    .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
    .hub_r2(hub_r2), .hub_g2(hub_g2), .hub_b2(hub_b2),
    .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
    .hub_addr(hub_addr), .frame_done(frame_done)
  );

  // Pixel RAM with one cycle of read latency.
  always @(posedge sysclk) begin
    if (rclk) begin
      rdata1 <= mem1[raddr[NPIX_W-1:0]];
      rdata2 <= mem2[raddr[NPIX_W-1:0]];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int on_time(input int p);
    int w = BASE << p;
`ifdef HUB75_SCANOUT_BRIGHTNESS_EN
    return (w * int'(brightness)) >> 8;
`else
    return w;
`endif
  endfunction

  function automatic logic [5:0] exp_pix(input int a, input int p);
    logic [15:0] t, b;
    t = mem1[NPIX_W'(a)] >> p;
    b = mem2[NPIX_W'(a)] >> p;
    return {t[11], t[6], t[0], b[11], b[6], b[0]};
  endfunction

  // Reference state: which (row, plane) is latched next, and what the last one must show.
  logic [5:0]          shq[$];
  int                  rdq[$];
  int                  m_row, m_plane, prev_on, prev_w, oe_cnt, since_lat;
  int                  lat_total = 0, fd_total = 0, rclk_total = 0;
  bit                  has_prev, prev_last, fd_seen, wait_rclk, en_steady;
  logic                prev_clk, prev_lat, prev_oe_n;
  logic [ROW_BITS-1:0] prev_addr;
  logic [5:0]          prev_col, cur_col;

  always @(negedge sysclk) begin
    cur_col = {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2};
    if (!rst_n) begin
      shq.delete();
      rdq.delete();
      m_row = 0; m_plane = 0; oe_cnt = 0; since_lat = 0;
      has_prev = 0; fd_seen = 0; wait_rclk = 0; en_steady = 0;
      prev_clk = 0; prev_lat = 0; prev_oe_n = 1; prev_addr = '0; prev_col = '0;
    end else begin
      since_lat++;
      if (!enable) en_steady = 0;
      if (hub_clk && !prev_clk) begin
        check("shift_setup", int'(cur_col), int'(prev_col));
        shq.push_back(cur_col);
      end
      if (rclk) begin
        rclk_total++;
        check("raddr_range", int'(raddr < NPIX), 1);
        rdq.push_back(int'(raddr));
        if (wait_rclk) begin
          wait_rclk = 0;
          if (en_steady) check("show_len", since_lat, prev_w);
        end
      end
      if (hub_addr != prev_addr) check("addr_while_oe", int'({prev_oe_n, hub_oe_n}), 3);
      if (!hub_oe_n) oe_cnt++;
      if (frame_done) begin
        fd_seen = 1;
        fd_total++;
      end
      if (hub_lat && !prev_lat) begin
        lat_total++;
        if (has_prev) begin
          check("oe_time", oe_cnt, prev_on);
          check("frame_done", int'(fd_seen), int'(prev_last));
        end
        check("lat_oe_n", int'(hub_oe_n), 1);
        check("shift_count", shq.size(), COLS);
        check("read_count", rdq.size(), COLS);
        check("lat_row", int'(hub_addr), m_row);
        for (int c = 0; c < COLS; c++) begin
          if (c < shq.size()) check("pixel", int'(shq[c]), int'(exp_pix(m_row * COLS + c, m_plane)));
          if (c < rdq.size()) check("raddr_seq", rdq[c], m_row * COLS + c);
        end
        shq.delete();
        rdq.delete();
        prev_on   = on_time(m_plane);
        prev_w    = BASE << m_plane;
        prev_last = (m_row == ROWS - 1) && (m_plane == PLANES - 1);
        if (m_plane == PLANES - 1) begin
          m_plane = 0;
          m_row   = (m_row + 1) % ROWS;
        end else begin
          m_plane++;
        end
        has_prev = 1; oe_cnt = 0; fd_seen = 0; since_lat = 0;
        wait_rclk = 1; en_steady = enable;
      end
      prev_clk = hub_clk; prev_lat = hub_lat; prev_oe_n = hub_oe_n;
      prev_addr = hub_addr; prev_col = cur_col;
    end
  end

  task automatic tick();
    @(negedge sysclk);
    #1;
  endtask

  task automatic wait_lats(input string tag, input int n);
    int target = lat_total + n;
    int budget = 3000;
    while (lat_total < target && budget > 0) begin tick(); budget--; end
    check(tag, int'(lat_total >= target), 1);
  endtask

  task automatic wait_frames(input string tag, input int n);
    int target = fd_total + n;
    int budget = 6000;
    while (fd_total < target && budget > 0) begin tick(); budget--; end
    check(tag, int'(fd_total >= target), 1);
  endtask

  task automatic go_idle(input string tag);
    enable = 0;
    repeat (120) tick();
    check({tag, "_idle_oe_n"}, int'(hub_oe_n), 1);
    check({tag, "_idle_rclk"}, int'(rclk), 0);
  endtask

  task automatic fill(input logic [15:0] v1, input logic [15:0] v2, input bit rnd);
    for (int i = 0; i < NPIX; i++) begin
      mem1[i] = rnd ? 16'($urandom) : v1;
      mem2[i] = rnd ? 16'($urandom) : v2;
    end
  endtask

  initial begin
    int budget, pon, rc;
    fill('0, '0, 1);
    repeat (3) tick();
    check("rst_oe_n", int'(hub_oe_n), 1);
    check("rst_outs", int'({raddr, rclk, hub_clk, hub_lat, hub_addr, frame_done,
                            hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}), 0);

    // Release reset already enabled: three full frames of random pixels.
    enable = 1;
    rst_n  = 1;
    wait_frames("frame_first", 1);
    wait_frames("frame_three", 2);
    go_idle("timing");

    // Pure red top / pure blue bottom, then a pixel with only the LSBs of R and G set.
    fill(16'hF800, 16'h001F, 0);
    enable = 1;
    wait_lats("colour_rb", ROWS * PLANES);
    go_idle("colour_rb");
    fill(16'h0840, 16'h0000, 0);
    enable = 1;
    wait_lats("colour_lsb", ROWS * PLANES);
    go_idle("colour_lsb");

    // Drop enable mid-shift: the plane completes with full on-time and no more reads.
    fill('0, '0, 1);
    enable = 1;
    budget = 50;
    while (!rclk && budget > 0) begin tick(); budget--; end
    check("drop_rclk_seen", int'(rclk), 1);
    repeat (3) tick();
    enable = 0;
    wait_lats("drop_lat", 1);
    pon = prev_on;
    repeat (60) tick();
    rc = rclk_total;
    repeat (40) tick();
    check("drop_no_rclk", rclk_total, rc);
    check("drop_oe_time", oe_cnt, pon);
    check("drop_oe_n", int'(hub_oe_n), 1);

    // Asynchronous reset while the panel is lit.
    enable = 1;
    budget = 200;
    while (hub_oe_n && budget > 0) begin tick(); budget--; end
    check("rst_show_seen", int'(hub_oe_n), 0);
    @(posedge sysclk);
    #2 rst_n = 0;
    #1;
    check("rst_async_oe_n", int'(hub_oe_n), 1);
    check("rst_async_lat", int'(hub_lat), 0);
    @(posedge sysclk);
    #2 rst_n = 1;
    budget = 20;
    while (!rclk && budget > 0) begin tick(); budget--; end
    check("rst_raddr0", int'(raddr), 0);
    wait_lats("rst_lat", 1);
    check("rst_hub_addr0", int'(hub_addr), 0);
    go_idle("rst");

`ifdef HUB75_SCANOUT_BRIGHTNESS_EN
    brightness = 8'd128;
    enable = 1;
    wait_lats("bright_half", ROWS * PLANES + 1);
    go_idle("bright_half");
    brightness = 8'd0;
    enable = 1;
    wait_lats("bright_zero", ROWS * PLANES + 1);
    go_idle("bright_zero");
`endif

    // Randomised runs of pixels (and brightness, when present) with varying run lengths.
    for (int k = 0; k < 3; k++) begin
      fill('0, '0, 1);
`ifdef HUB75_SCANOUT_BRIGHTNESS_EN
      brightness = 8'($urandom);
`endif
      enable = 1;
      wait_frames("rand_frame", 1);
      repeat ($urandom_range(0, 40)) tick();
      go_idle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
